// File: rtl/log_pkg.sv
// ============================================================================
// Module      : log_pkg
// Description : Shared types and constants for the log RAM drain engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package log_pkg;

    // Default geometry of the 37-bit log RAM.
    localparam int LOG_ADDR_WIDTH = 8;
    localparam int LOG_DATA_WIDTH = 37;

    // Depth follows the RAM's own sizing formula (ADDR_WIDTH squared).
    localparam int LOG_DEPTH = LOG_ADDR_WIDTH ** 2;

    // Drain sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAPT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } log_state_t;

endpackage : log_pkg

`default_nettype wire

// File: rtl/log_out_reg.sv
// ============================================================================
// Module      : log_out_reg
// Description : Output holding register for drained log records. Holds
//               valid, data and source address stable until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_out_reg
    import log_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int ADDR_WIDTH = LOG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;

    // Capture a record on load; drop valid on clear (handshake or abort).
    // Data and address are left as-is on clear, they are only meaningful
    // while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_addr  <= i_addr;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;

endmodule : log_out_reg

`default_nettype wire

// File: rtl/log_ram_reader.sv
// ============================================================================
// Module      : log_ram_reader
// Description : Sequential drain engine for the log RAM. On start, reads
//               entries 0..len-1 in address order through the RAM's
//               registered read port and streams them out over valid/ready.
//               Reads that collide with a RAM write are retried.
// Config      : LOG_RAM_READER_CLR_EN - when defined, ram_clr pulses in the
//               DONE cycle after a complete drain; otherwise tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_ram_reader
    import log_pkg::*;
#(
    parameter int ADDR_WIDTH = LOG_ADDR_WIDTH,
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int DEPTH      = ADDR_WIDTH ** 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic                  out_ready,
    output logic                  ram_clr
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_ONE_LEN   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE_PTR   = ADDR_WIDTH'(1);

    log_state_t            r_state;
    log_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_rem;
    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_handshake;
    logic                  w_abort;
    logic                  w_last;
    logic                  w_out_valid;
    logic                  w_out_clear;

    // Requests longer than the RAM are cut to a full-depth drain.
    assign w_len_clamped = (len > c_DEPTH_LEN) ? c_DEPTH_LEN : len;

    // Abort only means something while a drain is in flight; in DONE the
    // engine is already on its way back to IDLE.
    assign w_abort = abort &&
                     ((r_state == ISSUE) || (r_state == CAPT) || (r_state == HOLD));

    assign w_last = (r_rem == c_ONE_LEN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, datapath strobes and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_handshake = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        ram_re      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_len_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy   = 1'b1;
                ram_re = 1'b1;
                // A concurrent write suppresses the RAM read: retry.
                if (!ram_we) begin
                    w_state_nxt = CAPT;
                end
            end
            CAPT: begin
                busy   = 1'b1;
                ram_re = 1'b1;
                // rd_data floats while we is high; the RAM's output
                // register still holds our word, so just wait it out.
                if (!ram_we) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (w_out_valid && out_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = w_last ? DONE : ISSUE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_abort) begin
            w_capture   = 1'b0;
            w_handshake = 1'b0;
            w_state_nxt = DONE;
        end
    end

    // Address pointer and remaining-entry counter. Start is only accepted
    // in IDLE, so a start during a drain never disturbs these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_rem <= '0;
        end else if (w_accept) begin
            r_ptr <= '0;
            r_rem <= w_len_clamped;
        end else if (w_handshake) begin
            r_ptr <= r_ptr + c_ONE_PTR;
            r_rem <= r_rem - c_ONE_LEN;
        end
    end

    assign ram_rd_addr = r_ptr;
    assign w_out_clear = w_handshake | w_abort;

    log_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_capture),
        .i_clear (w_out_clear),
        .i_data  (ram_rd_data),
        .i_addr  (r_ptr),
        .o_valid (w_out_valid),
        .o_data  (out_data),
        .o_addr  (out_addr)
    );

    assign out_valid = w_out_valid;

`ifdef LOG_RAM_READER_CLR_EN
    logic r_clr;

    // Clear request lands in the DONE cycle that follows the final
    // handshake; aborted or empty drains never reach this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr <= 1'b0;
        end else begin
            r_clr <= w_handshake && w_last;
        end
    end

    assign ram_clr = r_clr;
`else
    assign ram_clr = 1'b0;
`endif

endmodule : log_ram_reader

`default_nettype wire

// File: tb/tb_log_ram_reader.sv
// ============================================================================
// Module      : tb_log_ram_reader
// Description : Self-checking bench for log_ram_reader with a registered-read
//               RAM model, a record scoreboard and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_ram_reader;

    localparam int AW    = 8;
    localparam int DW    = 37;
    localparam int DEPTH = AW ** 2;

`ifdef LOG_RAM_READER_CLR_EN
    localparam bit c_CLR = 1'b1;
`else
    localparam bit c_CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          ram_re;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_we = 1'b0;
    wire  [DW-1:0] ram_rd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_ready = 1'b1;
    logic          ram_clr;

    always #5 clk = ~clk;

    log_ram_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .ram_re      (ram_re),
        .ram_rd_addr (ram_rd_addr),
        .ram_we      (ram_we),
        .ram_rd_data (ram_rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_ready   (out_ready),
        .ram_clr     (ram_clr)
    );

    // RAM model: registered read, suppressed while we is high; the read
    // port floats whenever we is high.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_reg;
    always @(posedge clk) begin
        if (ram_re && !ram_we) rd_reg <= mem[ram_rd_addr];
    end
    assign ram_rd_data = ram_we ? {DW{1'bz}} : rd_reg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit rnd   = 1'b0;

    // Scoreboard: expected records in delivery order.
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int            rd_idx      = 0;
    int            hs_count    = 0;
    int            last_hs_cyc = -1;
    logic [AW-1:0] last_addr   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a drain of n delivers entries 0..min(n,DEPTH)-1 in order.
    task automatic push_exp(input int n);
        int m;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m; i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(mem[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) begin
            out_ready = ($urandom_range(0, 3) != 0);
            ram_we    = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic do_start(input int n);
        len   = (AW+1)'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (out_valid) break;
            step();
        end
        chk(nm, out_valid, 1);
    endtask

    // Wait for done, check the DONE cycle, then step past it.
    task automatic wait_done(input int bound, input bit exp_clr, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            step();
        end
        chk("done_seen", done, 1);
        chk("busy_in_done", busy, 0);
        chk("clr_at_done", ram_clr, exp_clr);
        step();
        chk("done_one_cycle", done, 0);
    endtask

    task automatic monitor();
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (out_valid) chk("no_re_in_hold", ram_re, 0);
            if (ram_clr) chk("clr_with_done", done, 1);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                if (rd_idx >= exp_data.size()) begin
                    chk("extra_record", rd_idx, exp_data.size());
                end else begin
                    chk("rec_addr", out_addr, exp_addr[rd_idx]);
                    chk("rec_data", out_data, exp_data[rd_idx]);
                    rd_idx++;
                end
                last_addr   = out_addr;
                last_hs_cyc = cyc;
                hs_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
        end
    endtask

    initial begin
        int t0;
        int dc;
        int base;
        int n;

        for (int i = 0; i < (1 << AW); i++) mem[i] = {5'($urandom), $urandom};
        for (int i = 0; i < 4; i++) mem[i] = 37'h1_0000_0001 + 37'(i);

        fork
            monitor();
        join_none

        // Reset state.
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", ram_re, 0);
        chk("rst_addr", ram_rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_oaddr", out_addr, 0);
        chk("rst_clr", ram_clr, 0);
        rst_n = 1'b1;
        step();

        // Basic 4-entry drain with out_ready held high. The first ISSUE
        // cycle is t0+1; the record appears two cycles later, and each
        // following record three cycles after its predecessor.
        t0 = cyc;
        push_exp(4);
        do_start(4);
        chk("busy_after_start", busy, 1);
        wait_valid("valid_seen", 10);
        chk("first_valid_lat", cyc - t0, 3);
        wait_done(50, c_CLR, dc);
        chk("done_after_last_hs", dc, last_hs_cyc + 1);
        chk("done_lat", dc - t0, 13);
        chk("basic_count", rd_idx, exp_data.size());

        // Collisions: two ISSUE retries, then one stalled CAPT cycle.
        t0 = cyc;
        push_exp(2);
        do_start(2);
        ram_we = 1'b1;
        step();
        step();
        ram_we = 1'b0;
        step();
        ram_we = 1'b1;
        step();
        ram_we = 1'b0;
        chk("coll_not_yet", out_valid, 0);
        step();
        chk("coll_valid", out_valid, 1);
        chk("coll_lat", cyc - t0, 6);
        wait_done(50, c_CLR, dc);
        chk("coll_count", rd_idx, exp_data.size());

        // Backpressure on record 1; a start during the drain is ignored.
        push_exp(3);
        do_start(3);
        wait_valid("bp_rec0", 10);
        step();
        out_ready = 1'b0;
        wait_valid("bp_rec1", 10);
        start = 1'b1;
        len   = (AW+1)'(7);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_addr", out_addr, 1);
        out_ready = 1'b1;
        wait_done(50, c_CLR, dc);
        chk("bp_count", rd_idx, exp_data.size());

        // Zero length: done next cycle, no RAM access.
        t0 = cyc;
        do_start(0);
        chk("len0_done", done, 1);
        chk("len0_lat", cyc - t0, 1);
        chk("len0_re", ram_re, 0);
        wait_done(2, 1'b0, dc);
        chk("len0_re_after", ram_re, 0);

        // Oversized length is clamped to a full-depth drain.
        push_exp(DEPTH + 5);
        do_start(DEPTH + 5);
        wait_done(DEPTH * 3 + 20, c_CLR, dc);
        chk("big_last_addr", last_addr, DEPTH - 1);
        chk("big_count", rd_idx, exp_data.size());

        // Abort in CAPT of record 2, then a fresh drain from address 0.
        push_exp(2);
        base = hs_count;
        do_start(4);
        for (int i = 0; i < 40; i++) begin
            if (hs_count == base + 2) break;
            step();
        end
        chk("abort_two_recs", hs_count, base + 2);
        chk("abort_in_issue", ram_re, 1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_re", ram_re, 0);
        chk("abort_done", done, 1);
        chk("abort_clr", ram_clr, 0);
        step();
        chk("abort_idle", busy, 0);
        push_exp(2);
        do_start(2);
        chk("restart_addr", ram_rd_addr, 0);
        wait_done(50, c_CLR, dc);
        chk("abort_count", rd_idx, exp_data.size());

        // Reset while a record is held: the record is dropped.
        out_ready = 1'b0;
        do_start(4);
        wait_valid("rst_mid_valid", 10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid0", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_re", ram_re, 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Randomized lengths with random backpressure and write collisions.
        rnd = 1'b1;
        for (int k = 0; k < 15; k++) begin
            n = $urandom_range(0, 10);
            push_exp(n);
            do_start(n);
            wait_done(400, c_CLR && (n > 0), dc);
            chk("rnd_count", rd_idx, exp_data.size());
        end
        rnd       = 1'b0;
        out_ready = 1'b1;
        ram_we    = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_log_ram_reader

`default_nettype wire
